// File: rtl/fpga_private_ram_arbiter_if.sv
// rtl/fpga_private_ram_arbiter_if.sv - requester and RAM bank signal bundle for the private RAM arbiter
interface fpga_private_ram_arbiter_if #(
  parameter int NUM_PORTS  = 2,
  parameter int ADDR_WIDTH = 12
);
  // Requester side (TCDM req/gnt/r_valid)
  logic [NUM_PORTS-1:0]            req_i;
  logic [NUM_PORTS-1:0]            wen_i;
  logic [NUM_PORTS*4-1:0]          be_i;
  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i;
  logic [NUM_PORTS*32-1:0]         wdata_i;
  logic [NUM_PORTS-1:0]            gnt_o;
  logic [NUM_PORTS-1:0]            r_valid_o;
  logic [31:0]                     r_rdata_o;

  // RAM bank side
  logic                            ram_csn_o;
  logic                            ram_wen_o;
  logic [3:0]                      ram_be_o;
  logic [ADDR_WIDTH-1:0]           ram_addr_o;
  logic [31:0]                     ram_wdata_o;
  logic [31:0]                     ram_rdata_i;

  // Environment view: drives requests and returns bank read data
  modport master (
    output req_i, wen_i, be_i, addr_i, wdata_i, ram_rdata_i,
    input  gnt_o, r_valid_o, r_rdata_o,
    input  ram_csn_o, ram_wen_o, ram_be_o, ram_addr_o, ram_wdata_o
  );

  // Arbiter view
  modport slave (
    input  req_i, wen_i, be_i, addr_i, wdata_i, ram_rdata_i,
    output gnt_o, r_valid_o, r_rdata_o,
    output ram_csn_o, ram_wen_o, ram_be_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/fpga_private_ram_arbiter.sv
// rtl/fpga_private_ram_arbiter.sv - round-robin arbiter sharing one private L2 RAM bank
module fpga_private_ram_arbiter #(
  parameter int  NUM_PORTS  = 2,
  parameter int  ADDR_WIDTH = 12,
  localparam int PORT_W     = $clog2(NUM_PORTS)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  fpga_private_ram_arbiter_if.slave bus,
  input  logic                      cnt_clear_i,
  output logic [31:0]               conflict_cnt_o
);

  logic [PORT_W-1:0] rr_ptr;
  logic              resp_valid;
  logic [PORT_W-1:0] resp_port;
  logic [31:0]       conflict_cnt;

  logic              found;
  logic              grant;
  logic [PORT_W-1:0] win;
  logic [PORT_W:0]   scan;
  logic [PORT_W-1:0] ptr_next;
  logic              conflict;

  // Scan ports starting at rr_ptr with explicit wrap; the first requester wins
  always_comb begin
    found = 1'b0;
    win   = '0;
    scan  = '0;
    for (int off = 0; off < NUM_PORTS; off++) begin
      scan = {1'b0, rr_ptr} + (PORT_W+1)'(off);
      if (scan >= (PORT_W+1)'(NUM_PORTS)) begin
        scan = scan - (PORT_W+1)'(NUM_PORTS);
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!found && (scan == (PORT_W+1)'(i)) && bus.req_i[i]) begin
          found = 1'b1;
          win   = PORT_W'(i);
        end
      end
    end
  end

  // No grants are issued while reset is held
  assign grant    = found && !rst_i;
  assign ptr_next = (win == PORT_W'(NUM_PORTS - 1)) ? '0 : win + 1'b1;
  assign conflict = $countones(bus.req_i) >= 2;

  // Drive the bank from the winner; idle bank keeps port 0's address/data
  always_comb begin
    bus.ram_csn_o   = 1'b1;
    bus.ram_wen_o   = 1'b1;
    bus.ram_be_o    = 4'b0000;
    bus.ram_addr_o  = bus.addr_i[ADDR_WIDTH-1:0];
    bus.ram_wdata_o = bus.wdata_i[31:0];
    bus.gnt_o       = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (grant && (win == PORT_W'(i))) begin
        bus.gnt_o[i]    = 1'b1;
        bus.ram_csn_o   = 1'b0;
        bus.ram_wen_o   = bus.wen_i[i];
        bus.ram_be_o    = bus.be_i[i*4 +: 4];
        bus.ram_addr_o  = bus.addr_i[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.ram_wdata_o = bus.wdata_i[i*32 +: 32];
      end
    end
  end

  // Route the pending response to its owner; read data passes straight through
  always_comb begin
    bus.r_valid_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      bus.r_valid_o[i] = resp_valid && (resp_port == PORT_W'(i));
    end
  end

  assign bus.r_rdata_o  = bus.ram_rdata_i;
  assign conflict_cnt_o = conflict_cnt;

  // Advance the priority pointer past each winner and remember who owns next cycle's response
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr     <= '0;
      resp_valid <= 1'b0;
      resp_port  <= '0;
    end else if (grant) begin
      rr_ptr     <= ptr_next;
      resp_valid <= 1'b1;
      resp_port  <= win;
    end else begin
      resp_valid <= 1'b0;
    end
  end

  // Saturating contention counter; clear beats increment
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt <= '0;
    end else if (cnt_clear_i) begin
      conflict_cnt <= '0;
    end else if (conflict && (conflict_cnt != 32'hFFFF_FFFF)) begin
      conflict_cnt <= conflict_cnt + 32'd1;
    end
  end

endmodule
